ldpc_encoder: RTL and testbench
===============================

Name: ldpc_encoder

Overview:
- Systematic IRA-style LDPC encoder; the transmit-side counterpart of the existing LDPC decoder.
- Accepts K info bits as an Avalon-ST packet of DW-bit beats.
- Emits an N=K+M bit codeword: the info bits unchanged, then M parity bits, as one Avalon-ST packet.
- Sits between the framing source and the modulator/channel model that feeds the decoder.

Parameters:
- DW, 2, bits per beat on both interfaces; must divide K and M.
- K, 64, info bits per codeword.
- M, 32, parity bits per codeword; power of 2.
- Q, 5, info-bit address stride.
- R, 11, column-offset step; j*R mod M must be distinct for j=0..DV-1.
- DV, 3, column weight (parity connections per info bit).

Ports:
- clk_clk  in  1  clock
- reset_reset  in  1  asynchronous active-high reset
- in_startofpacket  in  1  first info beat
- in_endofpacket  in  1  last info beat
- in_valid  in  1  info beat valid
- in_ready  out  1  encoder accepts beat
- in_data  in  DW  info bits; bit l = info index beat*DW+l
- out_startofpacket  out  1  first codeword beat
- out_endofpacket  out  1  last codeword beat
- out_valid  out  1  codeword beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  codeword bits; bit l = lower codeword index

Behaviour:
- Interface is fixed: one clock, clk_clk; reset_reset is asynchronous and active-high.
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_data=0, state=IDLE, beat counter=0, parity accumulator acc[M-1:0]=0, running parity r=0.
- Output stage: single register. It advances when !out_valid || out_ready ("adv").
- FSM IDLE:
  - in_ready=adv.
  - A beat with in_valid && in_startofpacket is accepted: acc cleared, then updated; beat sent to the output with out_sop=1; go to INFO; cnt=1.
  - A beat without sop is accepted and dropped; no output.
- FSM INFO:
  - in_ready=adv. Each accepted beat is copied to out_data with 1-cycle latency.
  - For each lane l, info index i=cnt*DW+l with bit 1 toggles acc[(i*Q + j*R) mod M] for j=0..DV-1.
  - Toggles within one beat compose by XOR; two lanes hitting the same address cancel.
  - After beat K/DW-1 is accepted, go to PARITY; cnt=0; r=0.
  - in_sop/in_eop are otherwise ignored; framing is count-based.
- FSM PARITY:
  - in_ready=0. On each adv, emit parity bits p[cnt*DW+l] for l=0..DW-1, computed in increasing index order.
  - p[n] = r ^ acc[n]; r then updates to p[n], i.e. prefix XOR (accumulator chain).
  - The last parity beat sets out_eop=1, then returns to IDLE.
- Throughput: one beat per cycle when out_ready=1. Codeword is N/DW=48 beats. Packets can run back-to-back, with the next sop accepted in the cycle after the last parity beat issues.
- Backpressure: out_ready=0 with out_valid=1 holds out_data/sop/eop stable; in_ready drops combinationally.
- Reset mid-packet discards all state and returns to IDLE; no partial eop is emitted.

Optional Feature:
- Macro LDPC_ENCODER_FRAMING_CHECK_EN.
- When defined:
  - Adds output err_framing (1 bit, reset 0), which pulses high for one cycle on any of:
    - in_eop missing on beat K/DW-1;
    - in_eop on an earlier beat;
    - in_sop during INFO.
  - in_sop during INFO restarts the packet: acc cleared, cnt=1, new sop emitted. The previous output packet is left without eop.
- When undefined: port absent; count-only framing as above.

Decomposition:
- Package ldpc_enc_pkg holds:
  - constants K, M, Q, R, DV, DW defaults;
  - derived N and beat counts;
  - state enum {IDLE, INFO, PARITY};
  - function addr(i,j).
- One sub-module, ldpc_enc_parity_acc: the M-bit accumulator with clear/update-per-beat and the prefix-XOR emit logic.
- The top level holds the FSM, counters and output register.

Test Plan:
- All-zero info, out_ready=1 -> 48 beats of 0; sop on beat 0, eop on beat 47; no gaps.
- Info bit 0=1, rest 0 -> acc bits {0,11,22} set; parity p[0..10]=1, p[11..21]=0, p[22..31]=1.
- Info bit 1=1 only -> acc bits {5,16,27}; parity p[0..4]=0, p[5..15]=1, p[16..26]=0, p[27..31]=1.
- Random info with out_ready toggling 50% -> codeword matches golden model; output held stable while stalled; in_ready=0 throughout PARITY.
- Two packets back-to-back, then reset_reset asserted at beat 20 of a third -> first two codewords correct; after reset, out_valid=0, IDLE, next packet encodes correctly.
- With LDPC_ENCODER_FRAMING_CHECK_EN: eop on beat 10 -> err_framing pulses once; sop mid-INFO -> restart, err_framing=1, new codeword correct.

Source files
------------

// File: rtl/ldpc_enc_pkg.sv
// Shared constants, state encoding and address helper for the IRA-style
// LDPC encoder.
//
// Code geometry (K info bits, M parity bits, DW bits per beat) and the
// interleaver constants (Q, R, DV) live here. Each info bit i toggles the
// accumulator bits addr(i, j) for j = 0..DV-1.
package ldpc_enc_pkg;

  localparam int DW = 2;    // bits per beat on both interfaces
  localparam int K  = 64;   // info bits per codeword
  localparam int M  = 32;   // parity bits per codeword (power of 2)
  localparam int Q  = 5;    // info-bit address stride
  localparam int R  = 11;   // column-offset step
  localparam int DV = 3;    // column weight

  localparam int N          = K + M;
  localparam int INFO_BEATS = K / DW;
  localparam int PAR_BEATS  = M / DW;
  localparam int CW_BEATS   = N / DW;

  localparam int CNT_W  = $clog2(INFO_BEATS > PAR_BEATS ? INFO_BEATS : PAR_BEATS);
  localparam int IDX_W  = $clog2(K);
  localparam int PIDX_W = $clog2(M);

  typedef enum logic [1:0] {
    IDLE,
    INFO,
    PARITY
  } state_t;

  // Accumulator bit touched by connection j of info bit i.
  function automatic logic [PIDX_W-1:0] addr(input int i, input int j);
    return PIDX_W'((i * Q + j * R) % M);
  endfunction

endpackage

// File: rtl/ldpc_enc_parity_acc.sv
// Parity accumulator for the LDPC encoder.
//
// Holds the M-bit accumulator acc and the running parity bit r.
//   clear      : start a new codeword (acc replaced by this beat's toggles)
//   update     : apply the toggles of info_data at info index info_base
//   par_start  : reset the running parity r before the first parity beat
//   emit       : advance r past the parity bits presented on par_bits
//   par_base   : parity index of par_bits[0]
//   par_bits   : p[par_base + l] = prefix XOR of acc up to that index
module ldpc_enc_parity_acc
  import ldpc_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              update,
  input  logic [IDX_W-1:0]  info_base,
  input  logic [DW-1:0]     info_data,
  input  logic              par_start,
  input  logic              emit,
  input  logic [PIDX_W-1:0] par_base,
  output logic [DW-1:0]     par_bits
);

  logic [M-1:0] acc;
  logic [M-1:0] toggle;
  logic         r;
  logic         r_chain;

  // All toggles of one beat fold into a single mask; two hits on the same
  // address cancel, which is exactly the GF(2) sum.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    toggle = '0;
    for (int l = 0; l < DW; l++) begin
      for (int j = 0; j < DV; j++) begin
        if (update && info_data[l]) begin
          toggle[addr(int'(info_base) + l, j)] = ~toggle[addr(int'(info_base) + l, j)];
        end
      end
    end
  end

  // Accumulator chain: each parity bit is the previous one XOR acc[n], lanes
  // processed in increasing index order within the beat.
  // NOTE: blocking assignments here are intentional; r_chain is a
  // combinational ripple through the lanes, not state.
  always_comb begin
    r_chain  = r;
    par_bits = '0;
    for (int l = 0; l < DW; l++) begin
      r_chain     = r_chain ^ acc[par_base + PIDX_W'(l)];
      par_bits[l] = r_chain;
    end
  end

  // NOTE: acc is a plain flop vector, not a RAM, so it takes the async reset
  // like every other state bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      r   <= 1'b0;
    end else begin
      if (clear) acc <= toggle;
      else       acc <= acc ^ toggle;
      if (par_start) r <= 1'b0;
      else if (emit) r <= r_chain;
    end
  end

endmodule

// File: rtl/ldpc_encoder.sv
// Systematic IRA-style LDPC encoder (top level).
//
// Takes K info bits as one Avalon-ST packet of DW-bit beats and emits the
// N = K + M bit codeword (info bits unchanged, then M parity bits) as one
// Avalon-ST packet. Framing is count-based; a single output register sits on
// the source side.
//
// Ports:
//   clk_clk, reset_reset            clock, asynchronous active-high reset
//   in_*  (sop, eop, valid, ready, data)   info sink
//   out_* (sop, eop, valid, ready, data)   codeword source
//   err_framing                     framing error pulse (optional)
//
// Optional feature, macro LDPC_ENCODER_FRAMING_CHECK_EN: adds err_framing,
// which pulses on a missing/early in_eop or an in_sop inside INFO; an in_sop
// inside INFO also restarts the codeword.
module ldpc_encoder
  import ldpc_enc_pkg::*;
(
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          in_startofpacket,
  input  logic          in_endofpacket,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_startofpacket,
  output logic          out_endofpacket,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
  ,
  output logic          err_framing
`endif
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               adv, accept, last_info, last_par;
  logic               valid_nxt, sop_nxt, eop_nxt;
  logic [DW-1:0]      data_nxt;
  logic               acc_clear, acc_update, par_start, emit;
  logic [IDX_W-1:0]   info_base;
  logic [PIDX_W-1:0]  par_base;
  logic [DW-1:0]      par_bits;
  logic               err_nxt;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = (state != PARITY) && adv;
  assign accept    = in_valid && in_ready;
  assign last_info = (cnt == CNT_W'(INFO_BEATS - 1));
  assign last_par  = (cnt == CNT_W'(PAR_BEATS - 1));
  assign par_base  = PIDX_W'(int'(cnt) * DW);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    valid_nxt  = out_valid;
    sop_nxt    = out_startofpacket;
    eop_nxt    = out_endofpacket;
    data_nxt   = out_data;
    acc_clear  = 1'b0;
    acc_update = 1'b0;
    par_start  = 1'b0;
    emit       = 1'b0;
    info_base  = IDX_W'(int'(cnt) * DW);
    err_nxt    = 1'b0;

    // The output slot drains on adv unless a new beat refills it below.
    if (adv) begin
      valid_nxt = 1'b0;
      sop_nxt   = 1'b0;
      eop_nxt   = 1'b0;
    end

    unique case (state)
      IDLE: begin
        // Beats without sop are accepted and dropped.
        if (accept && in_startofpacket) begin
          acc_clear  = 1'b1;
          acc_update = 1'b1;
          info_base  = '0;
          valid_nxt  = 1'b1;
          sop_nxt    = 1'b1;
          data_nxt   = in_data;
          state_nxt  = INFO;
          cnt_nxt    = CNT_W'(1);
`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
          err_nxt    = in_endofpacket;
`endif
        end
      end
      INFO: begin
        if (accept) begin
          acc_update = 1'b1;
          valid_nxt  = 1'b1;
          data_nxt   = in_data;
          if (last_info) begin
            state_nxt = PARITY;
            cnt_nxt   = '0;
            par_start = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
          if (in_startofpacket) begin
            // Restart: the partial codeword already sent is left without eop.
            acc_clear = 1'b1;
            info_base = '0;
            sop_nxt   = 1'b1;
            state_nxt = INFO;
            cnt_nxt   = CNT_W'(1);
            par_start = 1'b0;
            err_nxt   = 1'b1;
          end else begin
            err_nxt = (in_endofpacket != last_info);
          end
`endif
        end
      end
      PARITY: begin
        if (adv) begin
          emit      = 1'b1;
          valid_nxt = 1'b1;
          data_nxt  = par_bits;
          eop_nxt   = last_par;
          if (last_par) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state             <= IDLE;
      cnt               <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_data          <= '0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      out_valid         <= valid_nxt;
      out_startofpacket <= sop_nxt;
      out_endofpacket   <= eop_nxt;
      out_data          <= data_nxt;
    end
  end

`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) err_framing <= 1'b0;
    else             err_framing <= err_nxt;
  end
`else
  // Framing is purely count-based in this build; in_eop and the error term
  // have no consumer.
  logic unused_framing;
  assign unused_framing = in_endofpacket ^ err_nxt;
`endif

  ldpc_enc_parity_acc u_acc (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .clear     (acc_clear),
    .update    (acc_update),
    .info_base (info_base),
    .info_data (in_data),
    .par_start (par_start),
    .emit      (emit),
    .par_base  (par_base),
    .par_bits  (par_bits)
  );

endmodule

// File: tb/tb_ldpc_encoder.sv
`timescale 1ns/1ps
module tb_ldpc_encoder;
  import ldpc_enc_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_sop, in_eop, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_sop, out_eop, out_valid, out_ready;
  logic [DW-1:0] out_data;
`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
  logic          err_framing;
`endif

  ldpc_encoder dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data)
`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
    ,
    .err_framing       (err_framing)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder straight from the code definition: each set info bit
  // flips DV accumulator positions, parity is the running XOR of acc.
  function automatic logic [N-1:0] encode(input logic [K-1:0] info);
    logic [M-1:0] acc;
    logic [M-1:0] p;
    logic         run;
    acc = '0;
    p   = '0;
    run = 1'b0;
    for (int i = 0; i < K; i++)
      if (info[i])
        for (int j = 0; j < DV; j++) acc[(i * Q + j * R) % M] ^= 1'b1;
    for (int n = 0; n < M; n++) begin
      run  = run ^ acc[n];
      p[n] = run;
    end
    return {p, info};
  endfunction

  // ---------------- clock-cycle stamp, ready generator, monitor -----------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit ready_rand = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;
  beat_t rxq[$];
  int err_pulses = 0;

  initial begin
    logic            stall;
    logic [DW+1:0]   held;
    beat_t           b;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall)
          check("stall hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, held});
        if (out_valid && out_ready) begin
          b.sop = out_sop; b.eop = out_eop; b.data = out_data; b.cyc = cyc;
          rxq.push_back(b);
        end
        stall = out_valid && !out_ready;
        held  = {out_sop, out_eop, out_data};
`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
        if (err_framing) err_pulses++;
`endif
      end
    end
  end

  // ---------------- driver -----------------------------------------------
  task automatic drive_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                            output bit ok);
    int guard;
    guard = 0;
    ok    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
    while (guard < 1000) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      guard++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_in();
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Sends nbeats info beats; eop on eop_beat and on the final info beat.
  task automatic send_packet(input logic [K-1:0] info, input int nbeats, input int eop_beat,
                             input bit par_check);
    bit ok;
    bit leaked;
    int g;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(info[b*DW +: DW], b == 0, (b == eop_beat) || (b == INFO_BEATS - 1), ok);
      if (!ok) begin
        check("in_ready timeout", 0, 1);
        release_in();
        return;
      end
    end
    release_in();
    if (par_check) begin
      leaked = 1'b0;
      g      = 0;
      while (g < 2000) begin
        @(negedge clk);
        if (out_valid && out_eop) break;
        if (in_ready) leaked = 1'b1;
        g++;
      end
      check("in_ready low in PARITY", {leaked, g < 2000}, 2'b01);
    end
  endtask

  // ---------------- collector --------------------------------------------
  int last_eop_cyc = -1;

  task automatic collect(input string name, input logic [N-1:0] exp, input bit gap_chk);
    logic [N-1:0]        got;
    logic [CW_BEATS-1:0] sops, eops;
    beat_t               b;
    int                  first_cyc;
    int                  guard;
    guard = 0;
    first_cyc = 0;
    while (rxq.size() < CW_BEATS && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (rxq.size() < CW_BEATS) begin
      check({name, " timeout"}, rxq.size(), CW_BEATS);
      return;
    end
    got = '0; sops = '0; eops = '0;
    for (int i = 0; i < CW_BEATS; i++) begin
      b = rxq.pop_front();
      got[i*DW +: DW] = b.data;
      sops[i] = b.sop;
      eops[i] = b.eop;
      if (i == 0) first_cyc = b.cyc;
      if (i == CW_BEATS - 1) begin
        if (gap_chk) begin
          check({name, " beat span"}, b.cyc - first_cyc, CW_BEATS - 1);
          if (last_eop_cyc >= 0)
            check({name, " sop after prev eop"}, first_cyc - last_eop_cyc, 1);
        end
        last_eop_cyc = b.cyc;
      end
    end
    check({name, " codeword"}, got, exp);
    check({name, " sop"}, sops, 1);
    check({name, " eop"}, eops, {1'b1, {(CW_BEATS-1){1'b0}}});
  endtask

  // ---------------- vector table -----------------------------------------
  typedef struct {
    string        name;
    logic [K-1:0] info;
    logic [M-1:0] par;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] info_a, info_b, info_c, info_d;
    logic         partial_eop;
    bit           ok;
    int           p0, g;

    vecs[0].name = "all zero"; vecs[0].info = 64'h0; vecs[0].par = 32'h0000_0000;
    vecs[1].name = "bit0";     vecs[1].info = 64'h1; vecs[1].par = 32'hFFC0_07FF;
    vecs[2].name = "bit1";     vecs[2].info = 64'h2; vecs[2].par = 32'hF800_FFE0;
    vecs[3].name = "bit0+1";   vecs[3].info = 64'h3; vecs[3].par = 32'h07C0_F81F;

    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset sop/eop",   {out_sop, out_eop}, 2'b00);
    check("reset out_data",  out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", in_ready, 1);

    // A beat without sop in IDLE is swallowed.
    drive_beat(2'b11, 1'b0, 1'b0, ok);
    release_in();
    repeat (5) @(negedge clk);
    check("no-sop beat dropped", {ok, rxq.size() == 0}, 2'b11);

    // Table vectors, back-to-back, out_ready held high.
    fork
      begin
        for (int v = 0; v < 4; v++) send_packet(vecs[v].info, INFO_BEATS, INFO_BEATS - 1, 1'b0);
      end
      begin
        for (int v = 0; v < 4; v++) collect(vecs[v].name, {vecs[v].par, vecs[v].info}, 1'b1);
      end
    join

    // Random info under 50% backpressure.
    ready_rand = 1'b1;
    for (int t = 0; t < 4; t++) begin
      info_a = {$urandom(), $urandom()};
      fork
        send_packet(info_a, INFO_BEATS, INFO_BEATS - 1, 1'b1);
        collect("random", encode(info_a), 1'b0);
      join
    end

    // Two packets back-to-back, then reset at beat 20 of a third.
    info_a = {$urandom(), $urandom()};
    info_b = {$urandom(), $urandom()};
    info_c = {$urandom(), $urandom()};
    fork
      begin
        send_packet(info_a, INFO_BEATS, INFO_BEATS - 1, 1'b0);
        send_packet(info_b, INFO_BEATS, INFO_BEATS - 1, 1'b0);
        send_packet(info_c, 20, INFO_BEATS - 1, 1'b0);
      end
      begin
        collect("b2b pkt1", encode(info_a), 1'b0);
        collect("b2b pkt2", encode(info_b), 1'b0);
      end
    join
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset sop/eop/data", {out_sop, out_eop, out_data}, 0);
    partial_eop = 1'b0;
    while (rxq.size() > 0) partial_eop |= rxq.pop_front().eop;
    check("partial pkt has no eop", partial_eop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", {out_valid, in_ready}, 2'b01);
    info_d = {$urandom(), $urandom()};
    fork
      send_packet(info_d, INFO_BEATS, INFO_BEATS - 1, 1'b1);
      collect("after reset", encode(info_d), 1'b0);
    join

`ifdef LDPC_ENCODER_FRAMING_CHECK_EN
    ready_rand = 1'b0;
    // Early eop on beat 10: one error pulse, codeword still intact.
    p0 = err_pulses;
    info_a = {$urandom(), $urandom()};
    fork
      send_packet(info_a, INFO_BEATS, 10, 1'b0);
      collect("early eop", encode(info_a), 1'b0);
    join
    check("early eop err pulses", err_pulses - p0, 1);

    // sop mid-INFO: 12 beats of one packet, then a fresh packet restarts.
    p0 = err_pulses;
    info_b = {$urandom(), $urandom()};
    info_c = {$urandom(), $urandom()};
    fork
      begin
        send_packet(info_b, 12, INFO_BEATS - 1, 1'b0);
        send_packet(info_c, INFO_BEATS, INFO_BEATS - 1, 1'b0);
      end
      begin
        g = 0;
        while (rxq.size() < 12 && g < 5000) begin
          @(negedge clk);
          g++;
        end
        partial_eop = 1'b0;
        for (int i = 0; i < 12 && rxq.size() > 0; i++) partial_eop |= rxq.pop_front().eop;
        check("aborted pkt no eop", {g < 5000, partial_eop}, 2'b10);
        collect("restart", encode(info_c), 1'b0);
      end
    join
    check("restart err pulses", err_pulses - p0, 1);
`endif

    repeat (5) @(negedge clk);
    check("queue empty at end", rxq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
